mem_loader: RTL

Bus initiator that drives the data-memory write and read ports from the core side of the memory interface. It takes a byte stream (host link or bench stimulus), packs it little-endian into 32-bit words, and writes them into `dmem` starting at `BASE_ADDR`. With verification compiled in, it reads the region back and checks a running checksum. It replaces the core on the `dmem_*` ports during program preload and releases the bus on `done`.

---
 rtl/mem_loader_pkg.sv | 7 +
 rtl/mem_loader_if.sv | 25 ++
 rtl/mem_loader_byte_packer.sv | 35 +++
 rtl/mem_loader.sv | 121 ++++++++++++
 4 files changed

// File: rtl/mem_loader_pkg.sv
// mem_loader_pkg: loader state encoding and the byte-strobe to bit-mask helper
package mem_loader_pkg;
  typedef enum logic [2:0] {IDLE, FILL, WRITE, VERIFY_REQ, VERIFY_WAIT, FINISH} state_t;
  function automatic logic [31:0] strb_mask(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction
endpackage

// File: rtl/mem_loader_if.sv
// mem_loader_if: byte-stream input and dmem write/read port bundle of the loader
interface mem_loader_if;
  logic in_valid;
  logic in_ready;
  logic [7:0] in_data;
  logic in_last;
  logic dmem_wready;
  logic dmem_wvalid;
  logic [31:0] dmem_waddr;
  logic [31:0] dmem_wdata;
  logic [3:0] dmem_wstrb;
  logic dmem_rready;
  logic dmem_rvalid;
  logic [31:0] dmem_raddr;
  logic dmem_rresp;
  logic [31:0] dmem_rdata;
  modport master (
    input in_valid, in_data, in_last, dmem_wvalid, dmem_rvalid, dmem_rresp, dmem_rdata,
    output in_ready, dmem_wready, dmem_waddr, dmem_wdata, dmem_wstrb, dmem_rready, dmem_raddr
  );
  modport slave (
    output in_valid, in_data, in_last, dmem_wvalid, dmem_rvalid, dmem_rresp, dmem_rdata,
    input in_ready, dmem_wready, dmem_waddr, dmem_wdata, dmem_wstrb, dmem_rready, dmem_raddr
  );
endinterface

// File: rtl/mem_loader_byte_packer.sv
// byte_packer: little-endian byte-to-word packing with per-lane strobes and last flag
module byte_packer (
  input logic clk,
  input logic resetb,
  input logic clear,
  input logic take,
  input logic [7:0] data,
  input logic last_in,
  input logic consume,
  output logic [31:0] word,
  output logic [3:0] strb,
  output logic last,
  output logic fill_done
);
  logic [1:0] idx;
  assign fill_done = take && (idx == 2'd3 || last_in);
  // lane accumulation; a consumed or cleared word restarts at lane 0
  always_ff @(posedge clk or negedge resetb)
    if (!resetb) begin
      idx <= '0;
      word <= '0;
      strb <= '0;
      last <= 1'b0;
    end else if (clear || consume) begin
      idx <= '0;
      word <= '0;
      strb <= '0;
      last <= 1'b0;
    end else if (take) begin
      word[{idx, 3'b000} +: 8] <= data;
      strb[idx] <= 1'b1;
      idx <= idx + 2'd1;
      last <= last_in;
    end
endmodule

// File: rtl/mem_loader.sv
// mem_loader: byte stream to dmem word loader; readback checksum verify when LOADER_VERIFY_EN is defined
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0002_0000,
  parameter int unsigned SIZE = 128 * 1024
) (
  input logic clk,
  input logic resetb,
  input logic start,
  mem_loader_if.master bus,
  output logic busy,
  output logic done,
  output logic error,
  output logic [15:0] word_count
);
  localparam logic [31:0] END_ADDR = BASE_ADDR + 32'(SIZE);
  state_t state, next;
  logic [31:0] ptr, ptr_nx, word;
  logic [3:0] strb;
  logic take, fill_done, wgrant, over, last, bad;
  assign take = bus.in_valid && bus.in_ready;
  assign wgrant = bus.dmem_wready && bus.dmem_wvalid;
  assign ptr_nx = ptr + 32'd4;
  assign over = wgrant && !last && ptr_nx == END_ADDR;
  byte_packer u_pack (
    .clk(clk),
    .resetb(resetb),
    .clear(state == IDLE),
    .take(take),
    .data(bus.in_data),
    .last_in(bus.in_last),
    .consume(wgrant),
    .word(word),
    .strb(strb),
    .last(last),
    .fill_done(fill_done)
  );
  assign bus.in_ready = state == FILL;
  assign bus.dmem_wready = state == WRITE;
  assign bus.dmem_waddr = ptr;
  assign bus.dmem_wdata = word;
  assign bus.dmem_wstrb = strb;
  assign busy = state != IDLE && state != FINISH;
  assign done = state == FINISH;
`ifdef LOADER_VERIFY_EN
  logic [31:0] csum, rsum, rsum_nx, rptr;
  logic [15:0] rcnt;
  logic [3:0] last_strb;
  logic rgrant, rdone;
  localparam state_t AFTER_LAST = VERIFY_REQ;
  assign rgrant = bus.dmem_rready && bus.dmem_rvalid;
  assign rdone = state == VERIFY_WAIT && bus.dmem_rresp && rcnt + 16'd1 == word_count;
  assign rsum_nx = rsum + (bus.dmem_rdata & (rdone ? strb_mask(last_strb) : '1));
  assign bad = rdone && rsum_nx != csum;
  assign bus.dmem_rready = state == VERIFY_REQ;
  assign bus.dmem_raddr = rptr;
  // write checksum, saved final strobe and readback pointer/count/sum
  always_ff @(posedge clk or negedge resetb)
    if (!resetb) begin
      csum <= '0;
      rsum <= '0;
      rptr <= '0;
      rcnt <= '0;
      last_strb <= '0;
    end else if (state == IDLE && start) begin
      csum <= '0;
      rsum <= '0;
      rptr <= BASE_ADDR;
      rcnt <= '0;
    end else begin
      if (wgrant) csum <= csum + (word & strb_mask(strb));
      if (wgrant && last) last_strb <= strb;
      if (state == VERIFY_WAIT && bus.dmem_rresp) begin
        rsum <= rsum_nx;
        rptr <= rptr + 32'd4;
        rcnt <= rcnt + 16'd1;
      end
    end
`else
  localparam state_t AFTER_LAST = FINISH;
  assign bad = 1'b0;
  assign bus.dmem_rready = 1'b0;
  assign bus.dmem_raddr = '0;
`endif
  // state register, write pointer, word counter and sticky error
  always_ff @(posedge clk or negedge resetb)
    if (!resetb) begin
      state <= IDLE;
      ptr <= '0;
      word_count <= '0;
      error <= 1'b0;
    end else begin
      state <= next;
      if (state == IDLE && start) begin
        ptr <= BASE_ADDR;
        word_count <= '0;
        error <= 1'b0;
      end
      if (wgrant) begin
        ptr <= ptr_nx;
        word_count <= word_count + 16'd1;
      end
      if (over || bad) error <= 1'b1;
    end
  // next state: a granted write ends the image, overflows, or returns to filling
  always_comb begin
    next = state;
    case (state)
      IDLE: next = start ? FILL : IDLE;
      FILL: next = fill_done ? WRITE : FILL;
      WRITE: next = !wgrant ? WRITE : last ? AFTER_LAST : over ? FINISH : FILL;
`ifdef LOADER_VERIFY_EN
      VERIFY_REQ: next = rgrant ? VERIFY_WAIT : VERIFY_REQ;
      VERIFY_WAIT: next = rdone ? FINISH : bus.dmem_rresp ? VERIFY_REQ : VERIFY_WAIT;
`endif
      FINISH: next = IDLE;
      default: next = IDLE;
    endcase
  end
endmodule
